// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with staged, tear-free updates
// Output registers lag the prescaler/index state by one cycle; frame_tick shares that lag.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int DWELL       = 1000,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 1,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic                    ready,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG_INV = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [5*NUM_DIGITS-1:0] sh_val, st_val;
    logic [NUM_DIGITS-1:0]   sh_blank, st_blank;
    logic                    pending;

    logic                    last_cnt, last_idx, frame_end, accept;
    logic [4:0]              cur_code;
    logic                    cur_dark;
    logic                    zeros_above;
    logic [NUM_DIGITS-1:0]   lz, an_nxt;

    function automatic logic [7:0] glyph(input logic [4:0] c);
        logic [4:0] neg;
        logic [3:0] mag;
        logic [7:0] g;
        neg = -c;
        mag = c[4] ? neg[3:0] : c[3:0];
        case (mag)
            4'h0: g = 8'hFC;  4'h1: g = 8'h60;  4'h2: g = 8'hDA;  4'h3: g = 8'hF2;
            4'h4: g = 8'h66;  4'h5: g = 8'hB6;  4'h6: g = 8'hBE;  4'h7: g = 8'hE0;
            4'h8: g = 8'hFE;  4'h9: g = 8'hE6;  4'hA: g = 8'hEE;  4'hB: g = 8'h3E;
            4'hC: g = 8'h9C;  4'hD: g = 8'h7A;  4'hE: g = 8'h9E;  default: g = 8'h8E;
        endcase
        return g | {7'b0, c[4]};
    endfunction

    assign ready     = ~pending;
    assign accept    = load & ready;
    assign last_cnt  = (cnt == CW'(DWELL - 1));
    assign last_idx  = (idx == IW'(NUM_DIGITS - 1));
    assign frame_end = last_cnt & last_idx;

    // Suppression walks down from the most significant digit; digit 0 always shows.
    always_comb begin
        zeros_above = 1'b1;
        lz          = '0;
        cur_code    = 5'd0;
        cur_dark    = 1'b0;
        an_nxt      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above & (sh_val[5*i +: 5] == 5'd0);
            lz[i]       = (LZ_SUPPRESS != 0) && (i != 0) && zeros_above;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = sh_val[5*i +: 5];
                cur_dark  = sh_blank[i] | lz[i];
                an_nxt[i] = (cnt != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_val     <= '0;
            sh_blank   <= '0;
            st_val     <= '0;
            st_blank   <= '0;
            pending    <= 1'b0;
            seg        <= SEG_INV;
            an         <= AN_INV;
            frame_tick <= 1'b0;
        end else begin
            cnt <= last_cnt ? '0 : cnt + 1'b1;
            if (last_cnt) begin
                idx <= last_idx ? '0 : idx + 1'b1;
            end
            seg        <= (cur_dark ? 8'h00 : glyph(cur_code)) ^ SEG_INV;
            an         <= an_nxt ^ AN_INV;
            frame_tick <= frame_end;
            // A load in the frame-end cycle cannot collide: ready is low whenever a swap is due.
            if (frame_end && pending) begin
                sh_val   <= st_val;
                sh_blank <= st_blank;
                pending  <= 1'b0;
            end else if (accept) begin
                st_val   <= value_in;
                st_blank <= blank_in;
                pending  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver, both polarities and LZ modes
// Frame-position model: expectations derive from the elapsed cycle count since reset.
module tb_seg_scan_driver;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int FR = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [19:0]   value_in = '0;
    logic [3:0]    blank_in = '0;
    logic          ready0, ready1, ft0, ft1;
    logic [7:0]    seg0, seg1;
    logic [3:0]    an0, an1;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .DWELL(DW), .SEG_ACT_LOW(0), .AN_ACT_LOW(1), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .blank_in(blank_in), .load(load),
        .ready(ready0), .seg(seg0), .an(an0), .frame_tick(ft0));
    seg_scan_driver #(.NUM_DIGITS(N), .DWELL(DW), .SEG_ACT_LOW(1), .AN_ACT_LOW(0), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .blank_in(blank_in), .load(load),
        .ready(ready1), .seg(seg1), .an(an1), .frame_tick(ft1));

    typedef struct {
        logic [7:0] seg0, seg1;
        logic [3:0] an0, an1;
        logic       ft, rdy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    bit          done = 1'b0;

    logic [7:0]  gtab[16];
    int          s;
    logic [19:0] m_sh_val, m_st_val;
    logic [3:0]  m_sh_bl, m_st_bl;
    bit          m_pend;

    function automatic logic [7:0] exp_seg(input int d, input bit lz);
        int  v, mag;
        bit  all_zero;
        v = int'(m_sh_val[5*d +: 5]);
        if (v >= 16) v = v - 32;
        all_zero = 1'b1;
        for (int j = d; j < N; j++) if (m_sh_val[5*j +: 5] != 5'd0) all_zero = 1'b0;
        if (m_sh_bl[d]) return 8'h00;
        if (lz && d != 0 && all_zero) return 8'h00;
        mag = (v < 0) ? ((-v) % 16) : v;
        return gtab[mag] | ((v < 0) ? 8'h01 : 8'h00);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, req);
        end
    endtask

    // One stimulus cycle: inputs set mid-low-phase, expectation for the next edge queued.
    task automatic cyc(input bit r, input bit ld, input logic [19:0] v, input logic [3:0] b);
        exp_t       e;
        int         p, d;
        bit         fe;
        logic [3:0] anl;
        @(negedge clk);
        #1;
        rst_n = r; load = ld; value_in = v; blank_in = b;
        if (!r) begin
            s = 0; m_sh_val = '0; m_st_val = '0; m_sh_bl = '0; m_st_bl = '0; m_pend = 1'b0;
            e = '{seg0: 8'h00, seg1: 8'hFF, an0: 4'hF, an1: 4'h0, ft: 1'b0, rdy: 1'b1};
        end else begin
            p   = s % DW;
            d   = (s / DW) % N;
            fe  = ((s % FR) == FR - 1);
            anl = (p == 0) ? 4'h0 : 4'(1 << d);
            e.seg0 = exp_seg(d, 1'b0);
            e.seg1 = ~exp_seg(d, 1'b1);
            e.an0  = ~anl;
            e.an1  = anl;
            e.ft   = fe;
            if (fe && m_pend) begin
                m_sh_val = m_st_val; m_sh_bl = m_st_bl; m_pend = 1'b0;
            end else if (ld && !m_pend) begin
                m_st_val = v; m_st_bl = b; m_pend = 1'b1;
            end
            e.rdy = !m_pend;
            s++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_lz0", seg0, e.seg0);
                chk("an_lz0", {4'h0, an0}, {4'h0, e.an0});
                chk("seg_lz1", seg1, e.seg1);
                chk("an_lz1", {4'h0, an1}, {4'h0, e.an1});
                chk("frame_tick0", {7'h0, ft0}, {7'h0, e.ft});
                chk("frame_tick1", {7'h0, ft1}, {7'h0, e.ft});
                chk("ready0", {7'h0, ready0}, {7'h0, e.rdy});
                chk("ready1", {7'h0, ready1}, {7'h0, e.rdy});
            end
        end
    end

    initial begin : stimulus
        int guard;
        gtab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                 8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        s = 0; m_sh_val = '0; m_st_val = '0; m_sh_bl = '0; m_st_bl = '0; m_pend = 1'b0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0);
        idle(3);
        // {-1,-16,A,7} followed by a second load that must be ignored
        cyc(1'b1, 1'b1, {5'h1F, 5'h10, 5'h0A, 5'h07}, 4'h0);
        idle(2);
        cyc(1'b1, 1'b1, {5'h03, 5'h03, 5'h03, 5'h03}, 4'h0);
        idle(40);
        cyc(1'b1, 1'b1, 20'h0, 4'h0);
        idle(40);
        cyc(1'b1, 1'b1, {5'h00, 5'h05, 5'h00, 5'h00}, 4'h0);
        idle(40);
        cyc(1'b1, 1'b1, {5'h02, 5'h1A, 5'h0F, 5'h08}, 4'b0101);
        idle(36);
        guard = 0;
        while (!((s % FR) == FR - 1 && !m_pend) && guard < 100) begin
            idle(1);
            guard++;
        end
        cyc(1'b1, 1'b1, {5'h11, 5'h0C, 5'h09, 5'h04}, 4'h0);
        idle(40);
        // reset mid-slot with data pending
        idle(5);
        cyc(1'b1, 1'b1, {5'h0E, 5'h0E, 5'h0E, 5'h0E}, 4'h0);
        idle(2);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        idle(40);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0)
                cyc(1'b0, 1'b0, '0, '0);
            else
                cyc(1'b1, $urandom_range(0, 7) == 0, 20'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        idle(2);
        @(posedge clk);
        #3;
        done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_DIGITS, 4, number of multiplexed digits, legal range 1..16.
- DWELL, 1000, clock cycles each digit stays selected, minimum 2.
- SEG_ACT_LOW, 0, 1 inverts all seg bits at the pin.
- AN_ACT_LOW, 1, 1 inverts all an bits at the pin.
- LZ_SUPPRESS, 0, 1 enables leading-zero blanking.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- value_in, in, 5*NUM_DIGITS, digit codes; digit i = value_in[5i+4:5i]; digit 0 least significant.
- blank_in, in, NUM_DIGITS, bit i = 1 forces digit i dark; sampled with value_in on load.
- load, in, 1, update request; accepted when load=1 and ready=1.
- ready, out, 1, 1 = staging register free.
- seg, out, 8, segments A..G,DP; A = bit 7, DP = bit 0; registered.
- an, out, NUM_DIGITS, one-hot digit enable; registered.
- frame_tick, out, 1, one-cycle pulse at each frame end.

Function
REQ-003 Each 5-bit code is two's complement, range -16..+15.
REQ-004 Glyphs for magnitudes 0..F (hex, logical polarity): FC 60 DA F2 66 B6 BE E0 FE E6 EE 3E 9C 7A 9E 8E.
REQ-005 A non-negative code v displays glyph(v) with DP off.
REQ-006 A negative code v displays glyph(|v| mod 16) OR 01; -16 (5'b10000) therefore displays FD.
REQ-007 Prescaler counts 0..DWELL-1 and wraps.
REQ-008 When the prescaler wraps, the digit index advances by one; the index wraps from NUM_DIGITS-1 to 0.
REQ-009 In prescaler cycle 0 of every slot, an is all inactive (anti-ghosting); in cycles 1..DWELL-1, an has exactly the current index bit active.
REQ-010 seg carries the decoded glyph of the current digit in every cycle of its slot, including the blank cycle.
REQ-011 A digit is dark (seg = 00 logical, an bit still driven per REQ-009) when its blank bit is 1, or when it is leading-zero suppressed.
REQ-012 Leading-zero suppression (LZ_SUPPRESS=1 only): a digit is suppressed when its code is 00000 and every more-significant digit is also 00000; digit 0 is never suppressed.
REQ-013 The display reads only the shadow register and never reads value_in or blank_in directly.
REQ-014 An accepted load copies value_in and blank_in into staging, sets pending, and drives ready=0 from the next cycle.
REQ-015 Load while ready=0 is ignored, with no change to staging.
REQ-016 Frame end is the cycle where prescaler=DWELL-1 and index=NUM_DIGITS-1.
REQ-017 At frame end with pending=1: shadow takes staging, pending clears, and ready=1 from the next cycle.
REQ-018 Display updates therefore never tear mid-frame.
REQ-019 A load accepted in the frame-end cycle itself is held until the following frame end.
REQ-020 frame_tick=1 in the cycle after every frame end, whether or not pending was set.
REQ-021 With NUM_DIGITS=1, the index stays at 0 and frame end occurs every DWELL cycles.
REQ-022 Polarity parameters affect only the output pins; all rules above are stated in logical polarity.

Reset
REQ-023 While rst_n=0, all state is asynchronously cleared: prescaler=0, index=0, shadow and staging codes=0, blank=0, pending=0.
REQ-024 While rst_n=0, outputs are: ready=1, frame_tick=0, seg all off, an all inactive (after pin polarity).
REQ-025 After rst_n deasserts, the first clock edge starts slot 0 of digit 0 with prescaler cycle 0 (blank).
REQ-026 Reset asserted mid-frame or while pending discards the staged data.

Verification (NUM_DIGITS=4, DWELL=4 unless stated)
REQ-027 Release reset, no load -> an cycles 0000,0001,0001,0001,0000,0010,... (logical); seg=FC throughout; frame_tick pulses every 16 cycles.
REQ-028 Load codes {d3..d0}={-1,-16,A,7} at cycle 3 -> ready=0 until the frame end; then seg shows E0, EE, FD, 61 for digits 0..3 in the next frame.
REQ-029 Second load while ready=0 -> ignored; the first data is displayed; ready returns to 1 the cycle after the frame end.
REQ-030 LZ_SUPPRESS=1, codes {0,0,0,0} -> digits 3..1 dark, digit 0 shows FC; codes {0,5,0,0} -> digit 3 dark, digits 2..0 show B6, FC, FC.
REQ-031 Load presented exactly in the frame-end cycle -> applied at the next frame end (16 cycles later), not the current one.
REQ-032 Assert rst_n=0 mid-slot with pending=1 -> outputs go off immediately; after release, the display shows all-zero codes and ready=1.
